// File: rtl/adc_spi_sampler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc_spi_sampler
//
// Periodically reads an external serial ADC over an SPI-style link (CPOL=0,
// data sampled on the rising SCLK edge), deserialises the frame MSB first and
// presents the right-aligned data field as a 16-bit code with a one-cycle
// valid strobe. Feeds the temperature converter's val_in.
//
// Frame timeline, edge 0 = the clk edge that drops CS:
//   SETUP : CS low, SCLK low for CLK_DIV cycles
//   SHIFT : SCLK rises at CLK_DIV*(2k-1), k = 1..FRAME_BITS, and then ends
//           with one more low half-period. It exits at CLK_DIV*(2*FRAME_BITS+1).
//   HOLD  : CS high (quiet time) for CLK_DIV cycles, then IDLE
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   enable    in   permits new frames to start
//   adc_miso  in   ADC serial data, synchronous to clk
//   adc_cs_n  out  ADC chip select, active low
//   adc_sclk  out  serial clock, idle low
//   val_out   out  last converted code, zero-extended, right-aligned
//   val_valid out  one-cycle pulse when val_out updates
//   lead_err  out  updated with val_out; 1 if any leading non-data bit was 1
//   busy      out  high while a frame is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module adc_spi_sampler #(
  parameter int CLK_DIV       = 4,    // clk cycles per SCLK half-period, >= 1
  parameter int FRAME_BITS    = 16,   // SCLK cycles per frame
  parameter int ADC_BITS      = 10,   // data bits at the tail of the frame
  parameter int SAMPLE_PERIOD = 1000  // clk cycles between frame starts
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] val_out,
  output logic        val_valid,
  output logic        lead_err,
  output logic        busy
);

  // Total busy time of one frame: SETUP + 2*FRAME_BITS+1 half-periods + HOLD.
  localparam int FRAME_CYCLES = CLK_DIV * (2 * FRAME_BITS + 2);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = (FRAME_BITS > 1) ? $clog2(2 * FRAME_BITS) : 1;
  localparam int PER_W  = $clog2(SAMPLE_PERIOD);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;     // clk cycles within the current half-period
  logic [HALF_W-1:0]     half_cnt;    // SCLK half-periods completed in SHIFT
  logic [PER_W-1:0]      period_cnt;  // position within the sample period
  logic [FRAME_BITS-1:0] shift_reg;   // frame bits, MSB received first
  logic                  div_last;

  assign div_last = (div_cnt == DIV_LAST);

  // Sample-period timer. It runs from the frame-start cycle and reaches 0
  // again exactly SAMPLE_PERIOD cycles later, which is the next start point.
  // Parked at 0 while idle and disabled, so a rising enable starts a frame on
  // the very next edge.
  // NOTE: every clocked block here uses non-blocking (<=) assignments so all
  // registers update together from pre-edge values; blocking assignments in
  // a clocked block create order-dependent simulation and sim/synth mismatch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (state == IDLE && !enable) begin
      period_cnt <= '0;
    end else if (period_cnt == PER_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PER_ONE;
    end
  end

  // Frame sequencer. All pin-facing outputs are registered here so nothing
  // reaches the ADC or the converter through combinational logic.
  // NOTE: the shift register is reset along with the control state; it is a
  // handful of flops, and a defined value keeps lead_err/val_out free of X
  // even if a frame were ever cut short before all bits arrived.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      half_cnt  <= '0;
      shift_reg <= '0;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b0;
      val_out   <= '0;
      val_valid <= 1'b0;
      lead_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      val_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && period_cnt == '0) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
          end
        end

        // CS-to-SCLK setup time; the first rising SCLK edge closes it.
        SETUP: begin
          if (div_last) begin
            state     <= SHIFT;
            div_cnt   <= '0;
            half_cnt  <= '0;
            adc_sclk  <= 1'b1;
            shift_reg <= FRAME_BITS'({shift_reg, adc_miso});
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        // Toggle SCLK at every terminal count. MISO is captured on the edge
        // that drives SCLK high. After the last falling edge one more low
        // half-period elapses before CS is released.
        SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (half_cnt == HALF_LAST) begin
              state     <= HOLD;
              adc_cs_n  <= 1'b1;
              val_out   <= 16'(shift_reg[ADC_BITS-1:0]);
              lead_err  <= |(shift_reg >> ADC_BITS);
              val_valid <= 1'b1;
            end else begin
              half_cnt <= half_cnt + HALF_ONE;
              adc_sclk <= ~adc_sclk;
              if (!adc_sclk) begin
                shift_reg <= FRAME_BITS'({shift_reg, adc_miso});
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        // CS quiet time before another frame may begin.
        HOLD: begin
          if (div_last) begin
            state   <= IDLE;
            busy    <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A whole frame plus one idle cycle must fit in a sample period, otherwise
  // starts would be skipped and the output rate would silently halve.
  period_fits: assert property (@(posedge clk) disable iff (reset)
                                SAMPLE_PERIOD >= FRAME_CYCLES + 1)
    else $error("adc_spi_sampler: SAMPLE_PERIOD %0d < frame length %0d + 1",
                SAMPLE_PERIOD, FRAME_CYCLES);

endmodule
